// File: rtl/mpp_pkg.sv
// ---------------------------------------------------------------------------
// mpp_pkg
// Shared definitions for the sequential ALU stage (alu_seq) and its
// combinational core (alu_core).
//   - DEFAULT_WIDTH : default datapath width
//   - OP_*          : 3-bit opcode values
//   - state_t       : 2-bit FSM state encoding (IDLE/EXEC/MUL/DONE)
// ---------------------------------------------------------------------------
package mpp_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_SHR  = 3'b110;
   localparam logic [2:0] OP_MUL  = 3'b111;
   // Opcode 111 acts as a pass-through of A when the multiplier is not built.
   localparam logic [2:0] OP_PASS = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational evaluation of the single-cycle ALU operations.
// Ports:
//   op     in  [2:0]        opcode (111 evaluates as PASS: result=a)
//   a      in  [WIDTH-1:0]  operand A
//   b      in  [WIDTH-1:0]  operand B
//   result out [WIDTH-1:0]  operation result, modulo 2^WIDTH
//   carry  out              carry / borrow / shifted-out bit
// ---------------------------------------------------------------------------
module alu_core
   import mpp_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   // Add and subtract are done one bit wider so the top bit is the carry
   // (or, for subtraction, the borrow, which is set exactly when a < b).
   always_comb begin
      result = a;
      carry  = 1'b0;
      case (op)
         OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
         OP_SUB: {carry, result} = {1'b0, a} - {1'b0, b};
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_SHL: begin
            result = a << 1;
            carry  = a[WIDTH-1];
         end
         OP_SHR: begin
            result = a >> 1;
            carry  = a[0];
         end
         default: begin
            result = a;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Sequential ALU stage feeding the accumulator. One operation per accepted
// start; result/carry/zero are registered and announced by a one-cycle done
// pulse. Single-cycle ops take 2 clocks from accept to done.
//
// Optional feature (macro ALU_MUL_EN): opcode 111 becomes an unsigned
// shift-add multiply over WIDTH clocks. Without the macro, opcode 111 is a
// pass-through of A and no multiply state is built.
//
// Ports:
//   clock   in               rising-edge clock
//   reset_n in               asynchronous active-low reset
//   start   in               request; sampled only in IDLE or DONE
//   op      in  [2:0]        opcode, captured with start
//   a       in  [WIDTH-1:0]  operand A (accumulator buffer)
//   b       in  [WIDTH-1:0]  operand B (data bus)
//   busy    out              high while in EXEC or MUL
//   done    out              one-cycle pulse, outputs freshly updated
//   result  out [WIDTH-1:0]  registered result, held until next done
//   carry   out              carry/borrow/shifted-out/overflow bit
//   zero    out              result == 0
// ---------------------------------------------------------------------------
module alu_seq
   import mpp_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero
);

   state_t           state;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] core_result;
   logic             core_carry;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (core_result),
      .carry  (core_carry)
   );

`ifdef ALU_MUL_EN
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CW-1:0]      iter;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH:0]     partial;
   logic [2*WIDTH-1:0] product_next;
   logic               last_iter;

   // Product register holds {accumulated high half, remaining multiplier}.
   // Each step adds A into the high half when the multiplier LSB is set,
   // then shifts the whole thing right, keeping the add's carry bit.
   always_comb begin
      partial      = {1'b0, product[2*WIDTH-1:WIDTH]} +
                     (product[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      product_next = {partial, product[WIDTH-1:1]};
      last_iter    = (iter == CW'(WIDTH - 1));
   end
`endif

   // Single FSM: accepts requests in IDLE/DONE, evaluates in EXEC or
   // iterates in MUL, and registers busy/done alongside the state so both
   // are glitch-free. A start seen in EXEC/MUL is simply dropped.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         carry   <= 1'b0;
         zero    <= 1'b0;
`ifdef ALU_MUL_EN
         iter    <= '0;
         product <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  op_q <= op;
                  a_q  <= a;
                  b_q  <= b;
                  busy <= 1'b1;
`ifdef ALU_MUL_EN
                  if (op == OP_MUL) begin
                     state   <= ST_MUL;
                     product <= {{WIDTH{1'b0}}, b};
                     iter    <= '0;
                  end else begin
                     state <= ST_EXEC;
                  end
`else
                  state <= ST_EXEC;
`endif
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               result <= core_result;
               carry  <= core_carry;
               zero   <= (core_result == '0);
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= ST_DONE;
            end
            ST_MUL: begin
`ifdef ALU_MUL_EN
               product <= product_next;
               iter    <= iter + 1'b1;
               if (last_iter) begin
                  result <= product_next[WIDTH-1:0];
                  carry  <= |product_next[2*WIDTH-1:WIDTH];
                  zero   <= (product_next[WIDTH-1:0] == '0);
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= ST_DONE;
               end
`else
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
`endif
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequential ALU stage directly upstream of the accumulator register.
- Takes operand A from the accumulator's buffer and operand B from the data bus.
- Computes one operation per start request and drives result plus a one-cycle done pulse; done is wired to the accumulator's load input.
- Single-cycle ops finish in 2 clocks. The optional multiply is iterative shift-add over WIDTH clocks.

Parameters:
- WIDTH, 8, datapath width of operands and result.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  operation request; sampled only in IDLE or DONE.
- op  input  3  opcode, captured with start.
- a  input  WIDTH  operand A (accumulator buffer), captured with start.
- b  input  WIDTH  operand B (data bus), captured with start.
- busy  output  1  high while in EXEC or MUL.
- done  output  1  one-cycle pulse; result/carry/zero valid and newly updated.
- result  output  WIDTH  registered result; holds until next done.
- carry  output  1  carry/borrow/shifted-out bit; holds until next done.
- zero  output  1  result == 0; holds until next done.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, busy=0, done=0, result=0, carry=0, zero=0, operand regs=0, iteration counter=0.
- Reset asserted mid-operation aborts it immediately. No done pulse is produced; outputs take reset values.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - start=1 at edge N captures op/a/b.
  - Goes to MUL if op=111 and ALU_MUL_EN is defined, else to EXEC.
- EXEC (busy=1):
  - At edge N+1, result/carry/zero are registered and the state goes to DONE.
  - done=1 for the cycle after edge N+1.
- DONE (done=1, busy=0):
  - start=1 is accepted exactly as in IDLE, allowing back-to-back ops with one op per 2 clocks.
  - Otherwise returns to IDLE.
- start while busy is ignored; it is not queued.
- Opcodes; all arithmetic is modulo 2^WIDTH:
  - 000 ADD: {carry,result}=a+b.
  - 001 SUB: result=a-b, carry=1 iff a<b (borrow).
  - 010 AND, 011 OR, 100 XOR: carry=0.
  - 101 SHL: result=a<<1, carry=a[WIDTH-1].
  - 110 SHR (logical): result=a>>1, carry=a[0].
  - 111: see Optional Feature.
- zero = (result==0) for every opcode.
- Operands are sampled only at accept; later changes to a/b/op do not affect the op in flight.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined, op 111 = unsigned MUL:
  - Shift-add over a 2*WIDTH product register in MUL state, one iteration per edge, counter 0..WIDTH-1.
  - Result registered on edge N+WIDTH, done in the following cycle; busy=1 throughout MUL.
  - result = low WIDTH bits of a*b; carry = OR of high WIDTH bits (overflow).
- Undefined, op 111 = PASS:
  - Goes through EXEC with result=a, carry=0, 2-clock latency.
  - No MUL state or product/counter registers are synthesised.

Decomposition:
- Package mpp_pkg:
  - Opcode constants OP_ADD..OP_MUL.
  - State encoding constants (IDLE/EXEC/MUL/DONE, 2-bit).
  - Default WIDTH constant.
- One natural sub-module: alu_core.
  - Purely combinational single-cycle op evaluation (op, a, b -> result, carry).
  - Instanced by alu_seq; the FSM, operand capture, and multiply iteration stay in alu_seq.

Test Plan:
- Reset: reset_n low mid-EXEC -> busy=0, done=0, result=0, carry=0, zero=0 immediately, asynchronously; no done after release.
- ADD overflow: start, op=000, a=8'hF0, b=8'h20 -> done exactly 2 edges after accept; result=8'h10, carry=1, zero=0.
- SUB borrow/zero:
  - a=8'h05, b=8'h06 -> result=8'hFF, carry=1.
  - Then back-to-back from DONE with a=8'h33, b=8'h33 -> result=0, carry=0, zero=1, done 2 clocks later.
- Shifts: SHL a=8'h81 -> result=8'h02, carry=1; SHR a=8'h81 -> result=8'h40, carry=1.
- Busy ignore: start re-pulsed with new a/b during EXEC/MUL -> ignored; single done with original operands' result.
- op=111:
  - With ALU_MUL_EN, a=8'd20, b=8'd13 -> result=8'h04, carry=1, busy high 8 cycles, done after edge N+8.
  - Without ALU_MUL_EN, same inputs -> result=8'd20, carry=0, 2-clock latency.
